// File: rtl/ifu_pc_fetch.sv
`timescale 1ns/1ps
// Instruction-fetch stage: owns the architectural PC, fetches from imem, holds the word for decode.
// Latency: at least 2 cycles per instruction (1 fetch + 1 hold); each imem wait-state or stall adds 1 cycle.
// Backpressure: stall holds the word in S_HOLD; imem_ready is waited on for up to TIMEOUT_CYCLES before erroring.
module ifu_pc_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_3000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc_in,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_out,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        addr_err,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  // Counter is 8 bits wide, enough for the 1..255 timeout range.
  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_cnt_nxt;
  logic [7:0]  w_wait_cnt_inc;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;
  logic        r_instr_vld;
  logic        w_instr_vld_nxt;
  logic        r_addr_err;
  logic        w_addr_err_nxt;
  logic        r_timeout_err;
  logic        w_timeout_err_nxt;
  logic        w_npc_aligned;

  assign w_wait_cnt_inc = r_wait_cnt + 8'd1;
  assign w_npc_aligned  = (npc_in[1:0] == 2'b00);

  // State register; reset abandons any outstanding fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-datapath decode; ready wins over a same-cycle timeout.
  always_comb begin
    w_state_nxt       = r_state;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_pc_nxt          = r_pc;
    w_instr_nxt       = r_instr;
    w_instr_vld_nxt   = r_instr_vld;
    w_addr_err_nxt    = r_addr_err;
    w_timeout_err_nxt = r_timeout_err;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          w_instr_nxt     = imem_rdata;
          w_instr_vld_nxt = 1'b1;
          w_wait_cnt_nxt  = 8'd0;
          w_state_nxt     = S_HOLD;
        end else if (w_wait_cnt_inc == LP_TIMEOUT) begin
          w_wait_cnt_nxt    = w_wait_cnt_inc;
          w_timeout_err_nxt = 1'b1;
          w_state_nxt       = S_ERR;
        end else begin
          w_wait_cnt_nxt = w_wait_cnt_inc;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          // The target is loaded even when misaligned so the faulting address stays visible.
          w_pc_nxt        = npc_in;
          w_instr_vld_nxt = 1'b0;
          if (w_npc_aligned) begin
            w_state_nxt = S_FETCH;
          end else begin
            w_addr_err_nxt = 1'b1;
            w_state_nxt    = S_ERR;
          end
        end
      end
      S_ERR: begin
        w_instr_vld_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath registers: PC, captured word, valid qualifier, sticky error flags, wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_instr       <= 32'd0;
      r_instr_vld   <= 1'b0;
      r_addr_err    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_wait_cnt    <= 8'd0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_vld   <= w_instr_vld_nxt;
      r_addr_err    <= w_addr_err_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
    end
  end

  // imem_req is decoded from state only, so there is no input-to-output path.
  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign pc_out      = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_vld;
  assign addr_err    = r_addr_err;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ifu_pc_fetch.sv
`timescale 1ns/1ps
// Bench for ifu_pc_fetch: directed fetch/hold/stall/error sequences with a scoreboard of captured words.
module tb_ifu_pc_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] npc_in;
  logic        stall;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc_out;
  logic [31:0] instr;
  logic        instr_valid;
  logic        addr_err;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t sb[$];

  logic [31:0] cur_pc;
  logic [31:0] cur_ins;
  logic        prev_vld = 1'b0;

  ifu_pc_fetch #(
    .RESET_PC      (32'h0000_3000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .npc_in     (npc_in),
    .stall      (stall),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .pc_out     (pc_out),
    .instr      (instr),
    .instr_valid(instr_valid),
    .addr_err   (addr_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each rising instr_valid must match the oldest expected fetch.
  always @(negedge clk) begin
    if (instr_valid === 1'b1 && !prev_vld) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected: instr_valid rose with pc %h instr %h, none expected", pc_out, instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_pc", pc_out, e.pc);
        chk("mon_instr", instr, e.ins);
      end
    end
    prev_vld = (instr_valid === 1'b1);
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"}, pc_out, 32'h0000_3000);
    chk({tag, "_addr"}, imem_addr, 32'h0000_3000);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_vld"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_aerr"}, {31'd0, addr_err}, 32'd0);
    chk({tag, "_terr"}, {31'd0, timeout_err}, 32'd0);
  endtask

  // Reset pulse across one full clock, released at a negedge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    imem_ready = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
  endtask

  // Serve one fetch: ready after 'waits' wait-states; expects the request at exp_addr.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] rdata, input int waits);
    int reqc;
    reqc = 0;
    for (int k = 0; k < 20 && imem_req !== 1'b1; k++) @(negedge clk);
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, exp_addr);
    for (int i = 0; i <= waits; i++) begin
      if (imem_req === 1'b1) reqc++;
      imem_ready = (i == waits);
      imem_rdata = (i == waits) ? rdata : (32'hBAD0_0000 + 32'(i));
      if (i == waits) sb.push_back('{pc: exp_addr, ins: rdata});
      @(negedge clk);
    end
    imem_ready = 1'b0;
    chk("req_cycles", 32'(reqc), 32'(waits + 1));
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_terr", {31'd0, timeout_err}, 32'd0);
    cur_pc  = exp_addr;
    cur_ins = rdata;
  endtask

  // In S_HOLD: stall for n cycles with a junk npc_in, then release and load npc.
  task automatic hold(input logic [31:0] npc, input int n);
    logic [31:0] junk [5];
    junk[0] = 32'h0000_1111;
    junk[1] = 32'h0000_3042;
    junk[2] = 32'hFFFF_FFFC;
    junk[3] = 32'h0000_0000;
    junk[4] = 32'h1234_5678;
    for (int i = 0; i < n; i++) begin
      stall = 1'b1;
      npc_in = junk[i % 5];
      imem_ready = 1'b1;
      imem_rdata = 32'hEEEE_0000 + 32'(i);
      @(negedge clk);
      chk("stall_pc", pc_out, cur_pc);
      chk("stall_instr", instr, cur_ins);
      chk("stall_vld", {31'd0, instr_valid}, 32'd1);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    imem_ready = 1'b0;
    stall = 1'b0;
    npc_in = npc;
    @(negedge clk);
    chk("load_pc", pc_out, npc);
    chk("load_vld", {31'd0, instr_valid}, 32'd0);
    chk("load_aerr", {31'd0, addr_err}, 32'd0);
  endtask

  initial begin
    int reqc;
    reset = 1'b1;
    npc_in = 32'd0;
    stall = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    cur_pc = 32'd0;
    cur_ins = 32'd0;
    #2;
    check_reset_vals("por");

    // Reset release and first fetch, then a sequential stream.
    do_reset();
    fetch(32'h0000_3000, 32'h3C01_0001, 0);
    hold(32'h0000_3004, 0);
    fetch(32'h0000_3004, 32'h2042_0004, 0);
    hold(32'h0000_3008, 0);
    fetch(32'h0000_3008, 32'h0043_1820, 0);

    // Stall for 5 cycles, then branch with 3 wait-states.
    hold(32'h0000_3040, 5);
    fetch(32'h0000_3040, 32'h1000_FFFF, 3);

    // Ready on the last allowed cycle must not raise timeout.
    hold(32'h0000_3044, 0);
    fetch(32'h0000_3044, 32'hAC22_0010, 15);

    // Sequential wrap at the top of the address space.
    hold(32'hFFFF_FFFC, 0);
    fetch(32'hFFFF_FFFC, 32'h0800_0C00, 0);
    hold(32'h0000_0000, 0);
    fetch(32'h0000_0000, 32'h2400_0001, 0);

    // Misaligned target: error, faulting PC kept, no further requests.
    stall = 1'b0;
    npc_in = 32'h0000_3042;
    @(negedge clk);
    chk("mis_aerr", {31'd0, addr_err}, 32'd1);
    chk("mis_pc", pc_out, 32'h0000_3042);
    chk("mis_vld", {31'd0, instr_valid}, 32'd0);
    chk("mis_terr", {31'd0, timeout_err}, 32'd0);
    reqc = 0;
    imem_ready = 1'b1;
    npc_in = 32'h0000_4000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || pc_out !== 32'h0000_3042 || addr_err !== 1'b1) reqc++;
    end
    imem_ready = 1'b0;
    chk("err_stuck_bad_cycles", 32'(reqc), 32'd0);

    // Timeout: memory never answers.
    do_reset();
    reqc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) reqc++;
      else if (reqc != 0) break;
    end
    chk("to_req_cycles", 32'(reqc), 32'd16);
    chk("to_terr", {31'd0, timeout_err}, 32'd1);
    chk("to_aerr", {31'd0, addr_err}, 32'd0);
    chk("to_vld", {31'd0, instr_valid}, 32'd0);
    chk("to_pc", pc_out, 32'h0000_3000);
    repeat (3) @(negedge clk);
    chk("to_sticky", {31'd0, timeout_err}, 32'd1);
    chk("to_req_off", {31'd0, imem_req}, 32'd0);

    // Asynchronous reset in the middle of a fetch.
    do_reset();
    fetch(32'h0000_3000, 32'h8C43_0000, 0);
    hold(32'h0000_3004, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("async");
    imem_ready = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    reset = 1'b0;
    chk("late_rdy_vld0", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    chk("late_rdy_vld1", {31'd0, instr_valid}, 32'd0);
    chk("late_rdy_req", {31'd0, imem_req}, 32'd1);
    imem_ready = 1'b0;
    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d checks %0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
